// File: rtl/alu_seq_exec_pkg.sv
// Shared ALUop encodings, FSM state codes and shift helpers for the sequential ALU.
// The FSM state codes are exported here so benches can decode the unit's state.
package alu_seq_exec_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOG   = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_kind_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic shift_kind_e shift_kind(input logic [3:0] op);
        case (op)
            ALU_SRL: return SH_RIGHT_LOG;
            ALU_SRA: return SH_RIGHT_ARITH;
            default: return SH_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Serial one-bit-per-cycle shifter: shift register, down-counter and last-step flag.
// value_next is the register shifted by one; last is high on the final step.
module alu_seq_shifter
    import alu_seq_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  shift_kind_e        kind,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   value_next,
    output logic               last
);

    logic [WIDTH-1:0]   shift_reg;
    logic [SHAMT_W-1:0] count_reg;
    shift_kind_e        kind_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            count_reg <= '0;
            kind_reg  <= SH_LEFT;
        end else if (load) begin
            shift_reg <= a;
            count_reg <= shamt;
            kind_reg  <= kind;
        end else if (count_reg != '0) begin
            shift_reg <= value_next;
            count_reg <= count_reg - SHAMT_W'(1);
        end
    end

    // Per-bit mux: left shifts pull from the bit below, right shifts from the bit above.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic left_src;
            logic right_src;
            if (gi == 0) begin : g_lsb
                assign left_src = 1'b0;
            end else begin : g_mid_l
                assign left_src = shift_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign right_src = (kind_reg == SH_RIGHT_ARITH) ? shift_reg[WIDTH-1] : 1'b0;
            end else begin : g_mid_r
                assign right_src = shift_reg[gi+1];
            end
            assign value_next[gi] = (kind_reg == SH_LEFT) ? left_src : right_src;
        end
    endgenerate

    assign last = (count_reg == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execution unit with valid/ready on both sides and serial shifts.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal
);

    logic [1:0]         state_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               illegal_reg;
    logic               accept;
    logic [WIDTH-1:0]   op_value;
    logic               op_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic               go_shift;

    assign shamt    = in_b[SHAMT_W-1:0];
    // in_ready is a function of state and out_ready only, never of in_valid.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid   = (state_reg == DONE);
    assign out_result  = result_reg;
    assign out_illegal = illegal_reg;

    always_comb begin
        op_value   = '0;
        op_illegal = 1'b0;
        case (in_aluop)
            ALU_ADD:    op_value = in_a + in_b;
            ALU_SUB:    op_value = in_a - in_b;
            ALU_AND:    op_value = in_a & in_b;
            ALU_OR:     op_value = in_a | in_b;
            ALU_XOR:    op_value = in_a ^ in_b;
            ALU_SLT:    op_value[0] = $signed(in_a) < $signed(in_b);
            ALU_SLTU:   op_value[0] = in_a < in_b;
            ALU_COPY_B: op_value = in_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            ALU_SLL:    op_value = in_a << shamt;
            ALU_SRL:    op_value = in_a >> shamt;
            ALU_SRA:    op_value = WIDTH'($signed(in_a) >>> shamt);
`else
            // Serial path only finishes here for a zero shift amount.
            ALU_SLL, ALU_SRL, ALU_SRA: op_value = in_a;
`endif
            default:    op_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_FAST_SHIFT_EN
    assign go_shift = 1'b0;
`else
    logic             shift_load;
    logic             shift_last;
    logic [WIDTH-1:0] shift_value;

    assign shift_load = accept && is_shift_op(in_aluop);
    assign go_shift   = shift_load && (shamt != '0);

    alu_seq_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (shift_load),
        .kind       (shift_kind(in_aluop)),
        .a          (in_a),
        .shamt      (shamt),
        .value_next (shift_value),
        .last       (shift_last)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        if (go_shift) begin
                            state_reg <= SHIFT;
                        end else begin
                            state_reg   <= DONE;
                            result_reg  <= op_value;
                            illegal_reg <= op_illegal;
                        end
                    end else if ((state_reg == DONE) && out_ready) begin
                        state_reg <= IDLE;
                    end
                end
`ifndef ALU_SEQ_FAST_SHIFT_EN
                SHIFT: begin
                    if (shift_last) begin
                        state_reg   <= DONE;
                        result_reg  <= shift_value;
                        illegal_reg <= 1'b0;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Sequential ALU execution unit that consumes the 4-bit ALUop produced by the ALU decoder together with two operands, and returns a registered result.
- Logical, arithmetic, compare and COPY_B ops complete in one cycle.
- Shifts run serially, one bit per cycle, to save area in the ASIC datapath.
- Valid/ready handshakes on both sides allow the execute stage to stall on multi-cycle shifts.
- Opcode values come from the shared ALUop.vh macros.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, $clog2(WIDTH) = 5, shift-amount width (taken from B[SHAMT_W-1:0])

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit accepts request this cycle
in_aluop  input  4  ALUop (ALUop.vh encoding)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B / shift amount source
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_illegal  output  1  accepted op was ALU_XXX or an unlisted code

Behaviour:
- Reset is synchronous, active-high and forces state IDLE:
  - out_valid=0, out_result=0, out_illegal=0, counter=0.
  - in_ready=1 in the first cycle after reset deasserts.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept occurs when in_valid && in_ready. Operands and op are captured at accept and never re-sampled.
- Non-shift ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, COPY_B): result is computed and registered at accept, then go to DONE. Latency is 1 (out_valid the cycle after accept).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare; SLTU is unsigned. Both return 1 or 0 zero-extended.
  - COPY_B returns B.
- Shift ops (SLL, SRL, SRA):
  - At accept: load A into the shift register and B[SHAMT_W-1:0] into the down-counter.
  - If the count is 0, go straight to DONE (latency 1). Otherwise go to SHIFT.
  - In SHIFT, each cycle shifts by 1 and decrements the counter. SLL zero-fills the LSB, SRL zero-fills the MSB, SRA replicates the MSB. On the cycle the counter reaches 0, go to DONE.
  - Latency = 1 + shamt cycles; shamt=31 gives latency 32.
- Illegal op: result=0 and out_illegal=1, latency 1. out_illegal is valid only while out_valid=1.
- DONE:
  - out_result and out_illegal are held stable while out_valid && !out_ready.
  - If out_ready=1 and in_valid=0: go to IDLE, out_valid deasserts next cycle.
  - If out_ready=1 and in_valid=1: the new request is accepted in the same cycle, giving back-to-back single-cycle ops at one result per cycle.
- Reset asserted mid-SHIFT or in DONE aborts the operation. The pending result is discarded and no out_valid pulse appears.
- No combinational path from in_valid to in_ready. in_ready depends only on state and out_ready.

Optional Feature:
ALU_SEQ_FAST_SHIFT_EN:
- Defined: shifts use a single-cycle barrel shifter and behave like non-shift ops (latency 1). The SHIFT state and the counter are not generated, and in_ready never drops for a shift.
- Undefined: the serial shifter described above.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Opcode constants come from the existing ALUop.vh.
- Add FSM state localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) to a shared alu_seq_defs.vh header so the bench can observe state.
- One sub-module, alu_seq_shifter: shift register, counter and done flag. It is replaced by the combinational barrel path under ALU_SEQ_FAST_SHIFT_EN.

Test Plan:
1. ADD with A=32'hFFFF_FFFF, B=1, out_ready=1 -> out_valid the next cycle, result 32'h0000_0000, out_illegal=0.
2. SRA with A=32'h8000_0000, B=4 -> in_ready low for 4 cycles, out_valid at cycle 5, result 32'hF800_0000. SRL with the same operands -> 32'h0800_0000. With the fast-shift macro defined, latency is 1 for both.
3. SLT with A=32'hFFFF_FFFF, B=1 -> result 1. SLTU with the same operands -> result 0. SLL with B=0 -> result equals A, latency 1.
4. Backpressure: hold out_ready=0 for 3 cycles after an XOR result -> out_result stable and in_ready=0. Then out_ready=1 with in_valid=1 (OR) -> new result the next cycle with no bubble.
5. Reset asserted on the 3rd cycle of an SLL by 10 -> the following cycle out_valid=0 and in_ready=1. No stale result appears afterwards.
6. ALU_XXX with A=5, B=7 -> result 0, out_illegal=1 for exactly one result beat. The next op, ADD 2+3 -> result 5, out_illegal=0.
